pifo_access_ctrl: RTL and testbench
===================================

// Module: pifo_access_ctrl
// PURPOSE
//  Front-end controller for the two-push/one-pop flow scheduler PIFO. Shares the PIFO among NREQ
//  enqueue requesters with two-grant round-robin and fills push slots 1 and 2 each cycle.
//  Pushes and pops are interleaved so a pop never collides with a push; the PIFO drops a pop
//  that arrives alongside a push. Tracks occupancy with no lag and sequences the PIFO reset.
// PARAMETERS
//  NREQ     4   number of enqueue requesters (>=2)
//  N        10  PIFO capacity, must equal the scheduler's N
//  MAX_POPS 4   consecutive pop cycles allowed while pushes wait; the next cycle is then push-only
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        asynchronous active-low reset
//  req_valid    in   NREQ     requester i holds a push
//  req_rank     in   NREQ*32  rank of requester i (bits 32i+:32)
//  req_value    in   NREQ*32  value of requester i
//  req_ready    out  NREQ     grant; transfer occurs when req_valid[i] && req_ready[i]
//  pop_req      in   1        consumer asks for head (level, held until pop_ack)
//  pop_ack      out  1        pop accepted this cycle
//  out_valid    out  1        popped value valid (exactly one per pop_ack)
//  out_value    out  32       popped value
//  occ          out  $clog2(N+1) committed PIFO occupancy
//  fs_rst       out  1        synchronous active-high reset to the PIFO
//  fs_push_1/_2 out  1        push strobes; ranks/values on fs_push_rank_k / fs_push_value_k (32 each)
//  fs_pop       out  1        pop strobe
//  fs_pop_valid in   1        PIFO pop_valid;  fs_pop_value in 32: PIFO pop_value
// BEHAVIOUR
//  Reset (rst_n low, async): fs_rst=1, all fs_push/fs_pop=0, req_ready=0, pop_ack=0, occ=0,
//   out_valid=0, round-robin pointer=0, state=INIT.
//  FSM: INIT -> holds 2 cycles after rst_n rises (fs_rst=1, no grants) -> NORMAL.
//   NORMAL: if pop_req && occ>0 && pop_run<MAX_POPS, this is a pop cycle. Otherwise it is a
//   push cycle. pop_run increments per pop cycle that has any req_valid pending, and clears on
//   a push cycle or when none are pending. pop_run==MAX_POPS with pushes pending -> FORCE_PUSH.
//   FORCE_PUSH: one push cycle, no pop, then NORMAL.
//  Push cycle: grant up to 2 requesters, limited by room (occ<=N-2: 2; occ==N-1: 1; occ==N: 0).
//   First grant = first valid index at/after ptr (cyclic). Second = next valid after the first.
//   ptr <= last granted index + 1 mod NREQ. req_ready is combinational in the same cycle.
//  Issue: registered; command is on fs_* the cycle after the grant. First grant drives slot 1,
//   second drives slot 2. fs_push_2 is never 1 without fs_push_1. Never fs_pop && any fs_push.
//  occ updates at the grant edge: +granted pushes, -1 on pop_ack. Pop cycle and push grants are
//   mutually exclusive, so occ never exceeds N and never underflows.
//  Pop latency: pop_ack at cycle t -> fs_pop at t+1 -> out_valid/out_value at t+2, forwarded
//   from fs_pop_valid/fs_pop_value registered once. Back-to-back pops are allowed every cycle.
//  Boundaries: pop_req with occ==0 is ignored; the cycle is a push cycle. Full: no grants, pop
//   still allowed. rst_n mid-operation drops in-flight commands, and output out_valid clears.
// CONFIGURATION
//  PIFO_CTRL_DUAL_PUSH_EN defined: two grants per push cycle as above.
//  Not defined: at most one grant per cycle, only on slot 1. fs_push_2 is tied to 0, and the
//   room check needs only occ<N.
// STRUCTURE
//  Package pifo_pkg: DW=32, rank_t/value_t typedefs, and the push_cmd_t struct
//   {valid, rank, value}, also used by the scheduler.
//  Sub-module rr_pick2 (combinational): req vector + ptr + max_grants -> two one-hot grants,
//   and the next ptr. FSM, occ counter and issue registers stay in pifo_access_ctrl.
// TESTING
//  1 reset: rst_n low 3 cycles then high; fs_rst=1 until 2 cycles after rise, req_ready=0 throughout.
//  2 fairness: all 4 req_valid held, ptr=0; grants {0,1},{2,3},{0,1}; fs_push_1 rank=req0 rank.
//  3 full: N=10, occ=9, req 1 and 2 valid; only req1 granted, occ=10; next cycle no grants.
//  4 pop: pushes ranks 7,3,5 then pop_req x3; out_value order 3,5,7 at t+2 each; occ back to 0.
//  5 starvation: pop_req held, occ=10, req0 valid; 4 pop cycles then 1 push cycle granting req0.
//  6 empty: pop_req with occ=0 -> no pop_ack/fs_pop for 5 cycles; push then pop_ack next cycle.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared types for the PIFO scheduler and its access controller.
// Push command bundle, data widths and small sizing helpers.
package pifo_pkg;

    localparam int DW = 32;

    typedef logic [DW-1:0] rank_t;
    typedef logic [DW-1:0] value_t;

    typedef struct packed {
        logic   valid;
        rank_t  rank;
        value_t value;
    } push_cmd_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-grant round-robin picker: first two set requests at/after ptr.
// Grants are limited by i_max (0..2); next pointer follows the last grant.
module rr_pick2
    import pifo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    input  logic [1:0]      i_max,
    output logic [NREQ-1:0] o_gnt1,
    output logic [NREQ-1:0] o_gnt2,
    output logic [PW-1:0]   o_idx1,
    output logic [PW-1:0]   o_idx2,
    output logic [1:0]      o_ngnt,
    output logic [PW-1:0]   o_next_ptr
);

    // cyclic scan from the pointer, taking up to i_max requesters
    always_comb begin
        int j;
        o_gnt1     = '0;
        o_gnt2     = '0;
        o_idx1     = '0;
        o_idx2     = '0;
        o_ngnt     = 2'd0;
        o_next_ptr = i_ptr;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (i_req[j]) begin
                if (o_ngnt == 2'd0 && i_max != 2'd0) begin
                    o_gnt1[j]  = 1'b1;
                    o_idx1     = PW'(j);
                    o_ngnt     = 2'd1;
                    o_next_ptr = PW'((j + 1) % NREQ);
                end else if (o_ngnt == 2'd1 && i_max == 2'd2) begin
                    o_gnt2[j]  = 1'b1;
                    o_idx2     = PW'(j);
                    o_ngnt     = 2'd2;
                    o_next_ptr = PW'((j + 1) % NREQ);
                end
            end
        end
    end

endmodule

// File: rtl/pifo_access_ctrl.sv
// Front-end for the two-push/one-pop PIFO: arbitration, push/pop
// interleave, occupancy and PIFO reset. Macro: PIFO_CTRL_DUAL_PUSH_EN.
module pifo_access_ctrl
    import pifo_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int N        = 10,
    parameter int MAX_POPS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DW-1:0]     req_rank,
    input  logic [NREQ*DW-1:0]     req_value,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   pop_req,
    output logic                   pop_ack,
    output logic                   out_valid,
    output logic [DW-1:0]          out_value,
    output logic [$clog2(N+1)-1:0] occ,
    output logic                   fs_rst,
    output logic                   fs_push_1,
    output rank_t                  fs_push_rank_1,
    output value_t                 fs_push_value_1,
    output logic                   fs_push_2,
    output rank_t                  fs_push_rank_2,
    output value_t                 fs_push_value_2,
    output logic                   fs_pop,
    input  logic                   fs_pop_valid,
    input  logic [DW-1:0]          fs_pop_value
);

    localparam int OW = $clog2(N + 1);
    localparam int PW = ptr_w(NREQ);
    localparam int RW = $clog2(MAX_POPS + 1);

    typedef enum logic [1:0] {ST_INIT, ST_NORMAL, ST_FORCE} state_t;

    state_t    r_state;
    logic      r_init_cnt;
    logic [OW-1:0] r_occ;
    logic [PW-1:0] r_ptr;
    logic [RW-1:0] r_run;
    logic      r_fs_rst;
    push_cmd_t r_push1;
    push_cmd_t r_push2;
    logic      r_fs_pop;
    logic      r_out_valid;
    logic [DW-1:0] r_out_value;

    logic          w_pop_cycle;
    logic          w_push_cycle;
    logic [1:0]    w_max_gnt;
    logic [NREQ-1:0] w_gnt1;
    logic [NREQ-1:0] w_gnt2;
    logic [PW-1:0] w_idx1;
    logic [PW-1:0] w_idx2;
    logic [1:0]    w_ngnt;
    logic [PW-1:0] w_next_ptr;
    push_cmd_t     w_cmd1;
    push_cmd_t     w_cmd2;

    assign w_pop_cycle = (r_state == ST_NORMAL) && pop_req &&
                         (r_occ != '0) && (r_run < RW'(MAX_POPS));
    assign w_push_cycle = ((r_state == ST_NORMAL) && !w_pop_cycle) ||
                          (r_state == ST_FORCE);

    // room-limited grant budget for this push cycle
    always_comb begin
        w_max_gnt = 2'd0;
`ifdef PIFO_CTRL_DUAL_PUSH_EN
        if (w_push_cycle) begin
            if (r_occ <= OW'(N - 2))
                w_max_gnt = 2'd2;
            else if (r_occ == OW'(N - 1))
                w_max_gnt = 2'd1;
        end
`else
        if (w_push_cycle && (r_occ < OW'(N)))
            w_max_gnt = 2'd1;
`endif
    end

    rr_pick2 #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_req      (req_valid),
        .i_ptr      (r_ptr),
        .i_max      (w_max_gnt),
        .o_gnt1     (w_gnt1),
        .o_gnt2     (w_gnt2),
        .o_idx1     (w_idx1),
        .o_idx2     (w_idx2),
        .o_ngnt     (w_ngnt),
        .o_next_ptr (w_next_ptr)
    );

    // payload of the granted requesters, first grant on slot 1
    always_comb begin
        w_cmd1       = '0;
        w_cmd2       = '0;
        w_cmd1.valid = (w_ngnt != 2'd0);
        w_cmd1.rank  = req_rank[w_idx1*DW +: DW];
        w_cmd1.value = req_value[w_idx1*DW +: DW];
`ifdef PIFO_CTRL_DUAL_PUSH_EN
        w_cmd2.valid = (w_ngnt == 2'd2);
`else
        w_cmd2.valid = 1'b0;
`endif
        w_cmd2.rank  = req_rank[w_idx2*DW +: DW];
        w_cmd2.value = req_value[w_idx2*DW +: DW];
    end

    assign req_ready       = w_gnt1 | w_gnt2;
    assign pop_ack         = w_pop_cycle;
    assign occ             = r_occ;
    assign fs_rst          = r_fs_rst;
    assign fs_push_1       = r_push1.valid;
    assign fs_push_rank_1  = r_push1.rank;
    assign fs_push_value_1 = r_push1.value;
    assign fs_push_2       = r_push2.valid;
    assign fs_push_rank_2  = r_push2.rank;
    assign fs_push_value_2 = r_push2.value;
    assign fs_pop          = r_fs_pop;
    assign out_valid       = r_out_valid;
    assign out_value       = r_out_value;

    // control FSM, occupancy, pointer and registered PIFO commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= 1'b0;
            r_occ       <= '0;
            r_ptr       <= '0;
            r_run       <= '0;
            r_fs_rst    <= 1'b1;
            r_push1     <= '0;
            r_push2     <= '0;
            r_fs_pop    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_value <= '0;
        end else begin
            r_push1     <= w_cmd1;
            r_push2     <= w_cmd2;
            r_fs_pop    <= w_pop_cycle;
            r_out_valid <= r_fs_pop & fs_pop_valid;
            r_out_value <= fs_pop_value;
            r_occ       <= r_occ + OW'(w_ngnt) - OW'(w_pop_cycle);
            if (w_ngnt != 2'd0)
                r_ptr <= w_next_ptr;
            unique case (r_state)
                ST_INIT: begin
                    if (r_init_cnt) begin
                        r_state  <= ST_NORMAL;
                        r_fs_rst <= 1'b0;
                    end else begin
                        r_init_cnt <= 1'b1;
                    end
                end
                ST_NORMAL: begin
                    if (w_pop_cycle && (|req_valid)) begin
                        r_run <= r_run + RW'(1);
                        if (r_run == RW'(MAX_POPS - 1))
                            r_state <= ST_FORCE;
                    end else begin
                        r_run <= '0;
                    end
                end
                ST_FORCE: begin
                    r_run   <= '0;
                    r_state <= ST_NORMAL;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pifo_access_ctrl.sv
// Bench for pifo_access_ctrl: directed scenarios plus random traffic,
// checked each cycle against a queue-based model of the controller.
module tb_pifo_access_ctrl;
    import pifo_pkg::*;

    localparam int NREQ = 4;
    localparam int N    = 10;
    localparam int MAXP = 4;
`ifdef PIFO_CTRL_DUAL_PUSH_EN
    localparam int MAXG = 2;
    localparam logic [3:0] G0 = 4'b0011;
    localparam logic [3:0] G1 = 4'b1100;
    localparam logic [3:0] G2 = 4'b0011;
`else
    localparam int MAXG = 1;
    localparam logic [3:0] G0 = 4'b0001;
    localparam logic [3:0] G1 = 4'b0010;
    localparam logic [3:0] G2 = 4'b0100;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*32-1:0] req_rank, req_value;
    logic [NREQ-1:0] req_ready;
    logic pop_req, pop_ack, out_valid;
    logic [31:0] out_value;
    logic [$clog2(N+1)-1:0] occ;
    logic fs_rst, fs_push_1, fs_push_2, fs_pop;
    rank_t fs_push_rank_1, fs_push_rank_2;
    value_t fs_push_value_1, fs_push_value_2;
    logic fs_pop_valid;
    logic [31:0] fs_pop_value;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pifo_access_ctrl #(.NREQ(NREQ), .N(N), .MAX_POPS(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rank(req_rank), .req_value(req_value),
        .req_ready(req_ready), .pop_req(pop_req), .pop_ack(pop_ack),
        .out_valid(out_valid), .out_value(out_value), .occ(occ),
        .fs_rst(fs_rst),
        .fs_push_1(fs_push_1), .fs_push_rank_1(fs_push_rank_1),
        .fs_push_value_1(fs_push_value_1),
        .fs_push_2(fs_push_2), .fs_push_rank_2(fs_push_rank_2),
        .fs_push_value_2(fs_push_value_2),
        .fs_pop(fs_pop), .fs_pop_valid(fs_pop_valid),
        .fs_pop_value(fs_pop_value)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- PIFO environment (lowest rank, oldest first)
    logic [31:0] pr[16];
    logic [31:0] pvv[16];
    int ps[16];
    logic pv[16] = '{default: 1'b0};
    int seqc = 0;
    int pb;

    always_comb begin
        pb = -1;
        for (int i = 0; i < 16; i++) begin
            if (pv[i]) begin
                if (pb < 0) pb = i;
                else if (pr[i] < pr[pb] || (pr[i] == pr[pb] && ps[i] < ps[pb]))
                    pb = i;
            end
        end
        fs_pop_valid = fs_pop && (pb >= 0);
        fs_pop_value = (pb >= 0) ? pvv[pb] : 32'd0;
    end

    always @(posedge clk) begin : pifo_env
        int f;
        if (fs_rst) begin
            for (int i = 0; i < 16; i++) pv[i] <= 1'b0;
        end else begin
            if (fs_pop && pb >= 0) pv[pb] <= 1'b0;
            f = 0;
            if (fs_push_1) begin
                while (f < 15 && pv[f]) f++;
                pv[f] <= 1'b1; pr[f] <= fs_push_rank_1;
                pvv[f] <= fs_push_value_1; ps[f] <= seqc;
                seqc++; f++;
            end
            if (fs_push_2) begin
                while (f < 15 && pv[f]) f++;
                pv[f] <= 1'b1; pr[f] <= fs_push_rank_2;
                pvv[f] <= fs_push_value_2; ps[f] <= seqc;
                seqc++;
            end
        end
    end

    // ---------------- behavioural model and per-cycle compare
    typedef struct {
        logic [31:0] r;
        logic [31:0] v;
    } ent_t;
    ent_t mq[$];
    int m_init, m_ptr, m_run;
    bit m_force;
    bit e_p1, e_p2, e_pop, e_ov;
    logic [31:0] e_r1, e_v1, e_r2, e_v2, e_ovv, m_popv;

    always @(negedge clk) begin : model
        int room, ng, best;
        int gi[2];
        bit popc, pushc, norm;
        logic [NREQ-1:0] erdy;
        if (!rst_n) begin
            mq.delete();
            m_init = 0; m_ptr = 0; m_run = 0; m_force = 0;
            e_p1 = 0; e_p2 = 0; e_pop = 0; e_ov = 0;
            chk("rst fs_rst", fs_rst, 1);
            chk("rst ready", req_ready, 0);
            chk("rst pop_ack", pop_ack, 0);
            chk("rst occ", occ, 0);
            chk("rst cmds", {fs_push_1, fs_push_2, fs_pop}, 0);
            chk("rst out_valid", out_valid, 0);
        end else begin
            norm  = (m_init >= 2);
            popc  = norm && !m_force && pop_req && mq.size() > 0 && m_run < MAXP;
            pushc = norm && !popc;
            room  = N - mq.size();
            if (room > MAXG) room = MAXG;
            erdy = '0;
            ng = 0;
            if (pushc) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (req_valid[i] && ng < room) begin
                        gi[ng] = i; erdy[i] = 1'b1; ng++;
                    end
                end
            end
            chk("fs_rst", fs_rst, !norm);
            chk("req_ready", req_ready, erdy);
            chk("pop_ack", pop_ack, popc);
            chk("occ", occ, mq.size());
            chk("fs_push_1", fs_push_1, e_p1);
            if (e_p1) chk("slot1 data", {fs_push_rank_1, fs_push_value_1}, {e_r1, e_v1});
            chk("fs_push_2", fs_push_2, e_p2);
            if (e_p2) chk("slot2 data", {fs_push_rank_2, fs_push_value_2}, {e_r2, e_v2});
            chk("fs_pop", fs_pop, e_pop);
            chk("out_valid", out_valid, e_ov);
            if (e_ov) chk("out_value", out_value, e_ovv);
            e_ov  = e_pop;
            e_ovv = m_popv;
            e_pop = popc;
            e_p1  = (ng >= 1);
            e_p2  = (ng >= 2);
            if (ng >= 1) begin
                e_r1 = req_rank[gi[0]*32 +: 32];
                e_v1 = req_value[gi[0]*32 +: 32];
                mq.push_back('{e_r1, e_v1});
            end
            if (ng >= 2) begin
                e_r2 = req_rank[gi[1]*32 +: 32];
                e_v2 = req_value[gi[1]*32 +: 32];
                mq.push_back('{e_r2, e_v2});
            end
            if (ng > 0) m_ptr = (gi[ng-1] + 1) % NREQ;
            if (pushc) begin
                m_run = 0; m_force = 0;
            end
            if (popc) begin
                best = 0;
                for (int i = 1; i < mq.size(); i++)
                    if (mq[i].r < mq[best].r) best = i;
                m_popv = mq[best].v;
                mq.delete(best);
                if (|req_valid) begin
                    m_run++;
                    if (m_run == MAXP) m_force = 1;
                end else begin
                    m_run = 0;
                end
            end
            if (m_init < 2) m_init++;
        end
    end

    task automatic drain();
        bit done;
        done = 0;
        pop_req = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (occ == 0) done = 1;
            tick();
        end
        chk("drain reaches empty", done, 1);
        pop_req = 1'b0;
        repeat (3) tick();
    endtask

    // ---------------- stimulus with hand-computed expectations
    initial begin
        logic [31:0] outs[3];
        int nout, acks;
        rst_n = 1'b0; pop_req = 1'b0; req_valid = '1;
        req_rank  = {32'd103, 32'd102, 32'd101, 32'd100};
        req_value = {32'd203, 32'd202, 32'd201, 32'd200};
        repeat (3) begin
            @(negedge clk);
            chk("T1 reset fs_rst", fs_rst, 1);
            chk("T1 reset ready", req_ready, 0);
        end
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("T1 init0 fs_rst", fs_rst, 1);
        chk("T1 init0 ready", req_ready, 0);
        tick(); @(negedge clk);
        chk("T1 init1 fs_rst", fs_rst, 1);
        chk("T1 init1 ready", req_ready, 0);
        tick(); @(negedge clk);
        chk("T1 released fs_rst", fs_rst, 0);
        chk("T2 grant0", req_ready, G0);
        tick(); @(negedge clk);
        chk("T2 grant1", req_ready, G1);
        chk("T2 slot1 push", fs_push_1, 1);
        chk("T2 slot1 rank", fs_push_rank_1, 100);
        tick(); @(negedge clk);
        chk("T2 grant2", req_ready, G2);
        tick(); req_valid = '0;
        drain();

        // pop order by rank
        req_valid = 4'b0001;
        req_rank[31:0] = 7;  req_value[31:0] = 7;  tick();
        req_rank[31:0] = 3;  req_value[31:0] = 3;  tick();
        req_rank[31:0] = 5;  req_value[31:0] = 5;  tick();
        req_valid = '0; pop_req = 1'b1;
        nout = 0; acks = 0;
        for (int c = 0; c < 20 && nout < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin outs[nout] = out_value; nout++; end
            if (pop_ack) acks++;
            tick();
            if (acks >= 3) pop_req = 1'b0;
        end
        chk("T4 pop count", nout, 3);
        chk("T4 first", outs[0], 3);
        chk("T4 second", outs[1], 5);
        chk("T4 third", outs[2], 7);
        @(negedge clk);
        chk("T4 occ empty", occ, 0);
        tick();

        // full boundary
        req_valid = 4'b0001;
        repeat (9) tick();
        req_valid = 4'b0110;
        @(negedge clk);
        chk("T3 occ 9", occ, 9);
        chk("T3 one grant", req_ready, 4'b0010);
        tick(); @(negedge clk);
        chk("T3 occ full", occ, 10);
        chk("T3 no grant", req_ready, 0);

        // pop starvation guard
        tick(); req_valid = 4'b0001; pop_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("T5 pop cycle", pop_ack, 1);
            chk("T5 no grant", req_ready, 0);
            tick();
        end
        @(negedge clk);
        chk("T5 forced no pop", pop_ack, 0);
        chk("T5 forced grant", req_ready, 4'b0001);
        tick(); req_valid = '0;
        drain();

        // pop while empty
        pop_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("T6 empty pop_ack", pop_ack, 0);
            chk("T6 empty fs_pop", fs_pop, 0);
            tick();
        end
        req_valid = 4'b0001;
        @(negedge clk);
        chk("T6 push grant", req_ready, 4'b0001);
        tick(); req_valid = '0;
        @(negedge clk);
        chk("T6 pop_ack", pop_ack, 1);
        tick(); pop_req = 1'b0;
        repeat (4) tick();

        // random traffic with a mid-run reset
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
            end
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_rank[i*32 +: 32]  = $urandom_range(0, 50);
                req_value[i*32 +: 32] = $urandom;
            end
            if (((it / 150) % 2) == 1)
                pop_req = ($urandom_range(0, 3) != 0);
            else
                pop_req = ($urandom_range(0, 3) == 0);
            tick();
        end
        req_valid = '0; pop_req = 1'b0;
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
